// File: rtl/croc_pkg.sv
// croc_pkg: shared GPIO input-conditioning constants (pin count default, debounce counter width)
package croc_pkg;
  localparam int unsigned GpioCountDefault = 32;
  localparam int unsigned DebounceWidth    = 8;
endpackage

// File: rtl/gpio_in_debounce.sv
// gpio_in_debounce: per-pin 2-flop synchronizer, filtered level and edge pulses.
// Debounce counter is built only when GPIO_IN_COND_DEBOUNCE_EN is defined;
// otherwise the filtered level simply follows the synchronizer.
module gpio_in_debounce import croc_pkg::*; #(
  parameter int unsigned DebWidth = DebounceWidth
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                pad_i,
  input  logic                deb_en_i,
  input  logic [DebWidth-1:0] deb_limit_i,
  output logic                gpio_o,
  output logic                rise_o,
  output logic                fall_o
);
  logic [1:0] sync_q;
  logic       filt_q, filt_d, prev_q;
  logic       sync;
  assign sync = sync_q[1];
`ifdef GPIO_IN_COND_DEBOUNCE_EN
  logic [DebWidth-1:0] cnt_q, cnt_d;
  logic                mismatch, load;
  // filt follows sync once it has disagreed for more than deb_limit cycles; cnt never passes the limit
  always_comb begin
    mismatch = sync ^ filt_q;
    load     = !deb_en_i || (mismatch && cnt_q >= deb_limit_i);
    filt_d   = load ? sync : filt_q;
    cnt_d    = (!deb_en_i || !mismatch || load) ? '0 : cnt_q + 1'b1;
  end
  // stable-cycle counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
`else
  logic unused_deb;
  assign unused_deb = ^{deb_en_i, deb_limit_i};
  // without debounce the filtered level is the synchronized level, one cycle later
  always_comb filt_d = sync;
`endif
  // synchronizer, filtered level and its one-cycle history for edge detection
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      filt_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], pad_i};
      filt_q <= filt_d;
      prev_q <= filt_q;
    end
  end
  assign gpio_o = filt_q;
  assign rise_o = filt_q & ~prev_q;
  assign fall_o = ~filt_q & prev_q;
endmodule

// File: rtl/gpio_in_cond.sv
// gpio_in_cond: GPIO input conditioning (sync, optional debounce, edge detect, sticky IRQ pending).
// Define GPIO_IN_COND_DEBOUNCE_EN to build the per-pin debounce counters.
module gpio_in_cond import croc_pkg::*; #(
  parameter int unsigned GpioCount     = GpioCountDefault,
  parameter int unsigned DebounceWidth = croc_pkg::DebounceWidth
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [GpioCount-1:0]     pad_gpio_i,
  input  logic [GpioCount-1:0]     deb_en_i,
  input  logic [DebounceWidth-1:0] deb_limit_i,
  input  logic [GpioCount-1:0]     rise_en_i,
  input  logic [GpioCount-1:0]     fall_en_i,
  input  logic [GpioCount-1:0]     irq_clr_i,
  output logic [GpioCount-1:0]     gpio_o,
  output logic [GpioCount-1:0]     rise_o,
  output logic [GpioCount-1:0]     fall_o,
  output logic [GpioCount-1:0]     irq_pending_o,
  output logic                     irq_o
);
  logic [GpioCount-1:0] pend_q, pend_d;
  for (genvar g = 0; g < GpioCount; g++) begin : g_pin
    gpio_in_debounce #(.DebWidth(DebounceWidth)) u_deb (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .pad_i       (pad_gpio_i[g]),
      .deb_en_i    (deb_en_i[g]),
      .deb_limit_i (deb_limit_i),
      .gpio_o      (gpio_o[g]),
      .rise_o      (rise_o[g]),
      .fall_o      (fall_o[g])
    );
  end
  // a new enabled edge wins over a simultaneous clear
  always_comb pend_d = (pend_q & ~irq_clr_i) | (rise_o & rise_en_i) | (fall_o & fall_en_i);
  // sticky pending flags
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pend_q <= '0;
    else         pend_q <= pend_d;
  end
  assign irq_pending_o = pend_q;
  assign irq_o         = |pend_q;
endmodule

// File: tb/tb_gpio_in_cond.sv
// tb_gpio_in_cond: randomized + directed self-checking bench for gpio_in_cond against a run-length reference model
module tb_gpio_in_cond;
  import croc_pkg::*;
  localparam int G = 32;
  localparam int W = 8;
`ifdef GPIO_IN_COND_DEBOUNCE_EN
  localparam bit DEB = 1'b1;
`else
  localparam bit DEB = 1'b0;
`endif
  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic [G-1:0] pad, deb_en, rise_en, fall_en, clr;
  logic [W-1:0] lim;
  logic [G-1:0] gpio, rise, fall, pend;
  logic         irq;
  int checks = 0;
  int errors = 0;

  gpio_in_cond #(.GpioCount(G), .DebounceWidth(W)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .pad_gpio_i    (pad),
    .deb_en_i      (deb_en),
    .deb_limit_i   (lim),
    .rise_en_i     (rise_en),
    .fall_en_i     (fall_en),
    .irq_clr_i     (clr),
    .gpio_o        (gpio),
    .rise_o        (rise),
    .fall_o        (fall),
    .irq_pending_o (pend),
    .irq_o         (irq)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: pad seen two cycles late, level adopted after a mismatch run longer than the limit
  logic [G-1:0] d1_m, d2_m, lvl_m, last_m, pend_m;
  int           run_m [G];
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      d1_m <= '0; d2_m <= '0; lvl_m <= '0; last_m <= '0; pend_m <= '0;
      for (int i = 0; i < G; i++) run_m[i] <= 0;
    end else begin
      for (int i = 0; i < G; i++) begin
        if (!(DEB && deb_en[i])) begin
          lvl_m[i] <= d2_m[i];
          run_m[i] <= 0;
        end else if (d2_m[i] == lvl_m[i]) begin
          run_m[i] <= 0;
        end else if (run_m[i] + 1 > int'(lim)) begin
          lvl_m[i] <= d2_m[i];
          run_m[i] <= 0;
        end else begin
          run_m[i] <= run_m[i] + 1;
        end
      end
      pend_m <= (pend_m & ~clr) | (lvl_m & ~last_m & rise_en) | (~lvl_m & last_m & fall_en);
      last_m <= lvl_m;
      d1_m   <= pad;
      d2_m   <= d1_m;
    end
  end

  // every cycle: outputs against the model
  always @(negedge clk_i) begin
    check("gpio", gpio, lvl_m);
    check("rise", rise, lvl_m & ~last_m);
    check("fall", fall, ~lvl_m & last_m);
    check("pend", pend, pend_m);
    check("irq", irq, |pend_m);
  end

  task automatic wait_gpio(input int pin, input int bound, output int n);
    n = 0;
    while (!gpio[pin] && n < bound) begin
      @(negedge clk_i);
      n++;
    end
  endtask

  int n;
  logic seen;
  initial begin
    rst_ni = 1'b0; pad = '0; deb_en = '0; rise_en = '0; fall_en = '0; clr = '0; lim = '0;
    repeat (3) @(negedge clk_i);
    check("rst_gpio", gpio, 0);
    check("rst_irq", irq, 0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    // plain 3-cycle path with a single rise pulse
    pad[0] = 1'b1;
    wait_gpio(0, 50, n);
    check("lat_nodeb", n, 3);
    check("rise_first", rise[0], 1);
    @(negedge clk_i);
    check("rise_once", rise[0], 0);
    // short glitch vs stable level on a debounced pin
    lim = 4; deb_en[3] = 1'b1;
    repeat (2) @(negedge clk_i);
    pad[3] = 1'b1;
    repeat (3) @(negedge clk_i);
    pad[3] = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk_i);
      seen |= gpio[3];
    end
    check("glitch", seen, DEB ? 0 : 1);
    pad[3] = 1'b1;
    wait_gpio(3, 50, n);
    check("lat_deb", n, DEB ? 7 : 3);
    pad[3] = 1'b0;
    repeat (12) @(negedge clk_i);
    // rise-only pending, lone clear, clear colliding with a new set
    rise_en[5] = 1'b1;
    pad[5] = 1'b1;
    wait_gpio(5, 50, n);
    @(negedge clk_i);
    check("pend_rise", pend[5], 1);
    check("irq_rise", irq, 1);
    pad[5] = 1'b0;
    repeat (8) @(negedge clk_i);
    check("pend_nofall", pend[5], 1);
    clr[5] = 1'b1;
    @(negedge clk_i);
    clr[5] = 1'b0;
    check("pend_clr", pend[5], 0);
    pad[5] = 1'b1;
    wait_gpio(5, 50, n);
    check("rise_coll", rise[5], 1);
    clr[5] = 1'b1;
    @(negedge clk_i);
    clr[5] = 1'b0;
    check("pend_coll", pend[5], 1);
    // randomized traffic
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk_i);
      if (c % 150 == 0) begin
        deb_en = $urandom;
        lim = W'($urandom_range(0, 6));
      end
      if (c % 37 == 0) deb_en[$urandom_range(0, G - 1)] ^= 1'b1;
      if (c % 53 == 0) lim = W'($urandom_range(0, 6));
      if (c % 100 == 0) begin
        rise_en = $urandom;
        fall_en = $urandom;
      end
      pad ^= $urandom & $urandom & $urandom;
      clr = $urandom & $urandom & $urandom;
    end
    // async reset mid-count, pads held high through and after reset
    @(negedge clk_i);
    clr = '0; pad = '0; deb_en = '1; lim = 200;
    repeat (6) @(negedge clk_i);
    pad = '1;
    repeat (50) @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    check("arst_gpio", gpio, 0);
    check("arst_edges", rise | fall, 0);
    check("arst_pend", pend, 0);
    check("arst_irq", irq, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    wait_gpio(0, 400, n);
    check("lat_rst", n, DEB ? 203 : 3);
    check("rise_all", rise, {G{1'b1}});
    @(negedge clk_i);
    check("rise_all_once", rise, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/gpio_in_cond.md
GPIO_IN_COND -- requirements
Module: gpio_in_cond

Interface
REQ-001 SHALL have parameter GpioCount, default 32, the number of pad inputs conditioned.
REQ-002 SHALL have parameter DebounceWidth, default 8, the debounce counter and limit width.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state is in this domain.
REQ-004 SHALL have port rst_ni, input, 1, the reset; asynchronous, active-low.
REQ-005 SHALL have port pad_gpio_i, input, GpioCount, the raw asynchronous pad p2c levels.
REQ-006 SHALL have port deb_en_i, input, GpioCount, the per-pin debounce enable.
REQ-007 SHALL have port deb_limit_i, input, DebounceWidth, the stable-cycle limit N, shared by all pins.
REQ-008 SHALL have ports rise_en_i and fall_en_i, input, GpioCount each, the per-pin IRQ edge enables.
REQ-009 SHALL have port irq_clr_i, input, GpioCount, the per-pin one-cycle pending-clear pulses.
REQ-010 SHALL have port gpio_o, output, GpioCount, the conditioned level.
REQ-011 SHALL have ports rise_o and fall_o, output, GpioCount each, the one-cycle edge pulses.
REQ-012 SHALL have port irq_pending_o, output, GpioCount, the sticky pending flags.
REQ-013 SHALL have port irq_o, output, 1, the OR of irq_pending_o (combinational).

Function
REQ-014 Each pin SHALL pass through a 2-flop synchronizer; its output is "sync".
REQ-015 Each pin SHALL hold a filtered register "filt" (drives gpio_o) and a counter "cnt".
REQ-016 With deb_en_i=0, filt SHALL load sync every cycle and cnt SHALL stay 0; latency pad to gpio_o is 3 cycles.
REQ-017 With deb_en_i=1 and sync==filt, cnt SHALL clear to 0.
REQ-018 With deb_en_i=1, sync!=filt and cnt<deb_limit_i, cnt SHALL increment.
REQ-019 With deb_en_i=1, sync!=filt and cnt>=deb_limit_i, filt SHALL load sync and cnt SHALL clear; latency is 3+N cycles for a stable input.
REQ-020 Lowering deb_limit_i below an in-flight cnt SHALL update filt on the next mismatch cycle (>= compare); cnt SHALL never wrap.
REQ-021 A glitch shorter than N+1 synchronized cycles SHALL NOT change gpio_o.
REQ-022 rise_o SHALL be high for exactly the first cycle in which gpio_o is 1 after being 0, and fall_o likewise for 1->0.
REQ-023 A pending flag SHALL set in the cycle after (rise_o & rise_en_i) or (fall_o & fall_en_i).
REQ-024 irq_clr_i SHALL clear the pending flag in the next cycle; simultaneous set and clear SHALL leave it set.
REQ-025 Toggling deb_en_i mid-count SHALL clear cnt and SHALL NOT generate an edge unless filt changes.

Reset
REQ-026 Asserting rst_ni SHALL asynchronously clear synchronizer flops, filt, previous-filt, cnt and pending to 0.
REQ-027 During and after reset, every output SHALL be 0 with no spurious edge, including when a pad is held high through reset (first rise is a real edge).

Configuration
REQ-028 With macro GPIO_IN_COND_DEBOUNCE_EN defined, debounce logic per REQ-017..021 SHALL be built.
REQ-029 Without GPIO_IN_COND_DEBOUNCE_EN, no counters SHALL be built, deb_en_i and deb_limit_i SHALL be ignored, and every pin SHALL behave per REQ-016; the port list SHALL be unchanged.

Structure
REQ-030 croc_pkg SHALL hold the GpioCount default and the DebounceWidth constant.
REQ-031 A per-pin sub-module gpio_in_debounce (sync, filt, cnt, edge pulses) SHALL be instantiated GpioCount times in a generate loop; pending logic SHALL stay in gpio_in_cond.

Verification
REQ-032 Scenario: deb_en=0, pin0 driven 0->1 at cycle 10 -> gpio_o[0] high at cycle 13, rise_o[0] pulses once at 13.
REQ-033 Scenario: deb_en=1, N=4, pin3 pulse 3 cycles wide -> gpio_o[3] stays 0, no pulse; a stable level -> gpio_o[3] rises 7 cycles after the pad.
REQ-034 Scenario: rise_en[5]=1, fall_en[5]=0, pin5 goes 0->1->0 -> pending[5] and irq_o set once after the rise; no change on the fall.
REQ-035 Scenario: irq_clr[5] pulses in the same cycle as a new rise set on pin5 -> pending[5] stays 1; a later lone clear -> 0 next cycle.
REQ-036 Scenario: rst_ni dropped mid-count with N=200 -> all outputs 0 immediately; after release, pads held at 1 -> gpio_o rises after 203 cycles with one rise_o.
REQ-037 Scenario: build without GPIO_IN_COND_DEBOUNCE_EN, deb_en=all 1, N=255 -> 3-cycle latency on all 32 pins.
